// File: rtl/ysyx_220066_mdu_ctrl.sv
// M-extension sequencer: hands multiplies to an external multiplier and runs
// restoring radix-2 division in place, returning results over valid/ready.
module ysyx_220066_mdu_ctrl #(
  parameter int unsigned DIV_BITS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic        in_is_w,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        mul_req,
  output logic [1:0]  mul_op,
  output logic        mul_is_w,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result
);
  localparam int unsigned CW = $clog2(DIV_BITS);

  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]          op;
  logic                is_w;
  logic [CW-1:0]       cnt;
  logic [DIV_BITS-1:0] dvd, dsr, quo, rem;
  logic                q_neg, r_neg;

  logic                accept, sgn, s1, s2, div_zero, div_ovf, special, ge;
  logic [DIV_BITS-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_sel, q_fix, r_fix, fix_sel;
  logic [DIV_BITS:0]   rem_sh, diff;

  function automatic logic [63:0] w_adj(input logic w, input logic [DIV_BITS-1:0] v);
    return w ? 64'($signed(v[31:0])) : 64'(v);
  endfunction

  assign accept = in_valid && in_ready && !flush;
  assign sgn    = ~in_op[0];

  // Operand extraction happens before special-case detection so W-forms see 32-bit values.
  always_comb begin
    if (in_is_w) begin
      a_ext   = sgn ? DIV_BITS'($signed(src1[31:0])) : DIV_BITS'(src1[31:0]);
      b_ext   = sgn ? DIV_BITS'($signed(src2[31:0])) : DIV_BITS'(src2[31:0]);
      min_val = DIV_BITS'($signed(32'h8000_0000));
    end else begin
      a_ext   = DIV_BITS'(src1);
      b_ext   = DIV_BITS'(src2);
      min_val = DIV_BITS'(1) << (DIV_BITS - 1);
    end
    s1       = sgn && a_ext[DIV_BITS-1];
    s2       = sgn && b_ext[DIV_BITS-1];
    a_mag    = s1 ? -a_ext : a_ext;
    b_mag    = s2 ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    div_ovf  = sgn && (a_ext == min_val) && (b_ext == '1);
    special  = in_op[2] && (div_zero || div_ovf);
    if (div_zero) spec_sel = in_op[1] ? a_ext : '1;
    else          spec_sel = in_op[1] ? '0 : a_ext;
  end

  always_comb begin
    rem_sh  = {rem, dvd[cnt]};
    diff    = rem_sh - {1'b0, dsr};
    ge      = ~diff[DIV_BITS];
    q_fix   = q_neg ? -quo : quo;
    r_fix   = r_neg ? -rem : rem;
    fix_sel = op[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = !in_op[2] ? MUL_WAIT : (special ? DONE : DIV_RUN);
      MUL_WAIT: if (mul_done) state_nxt = DONE;
      DIV_RUN:  if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mul_req   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      mul_req   <= (state_nxt == MUL_WAIT);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= '0;
      is_w       <= 1'b0;
      mul_op     <= '0;
      mul_is_w   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      dvd        <= '0;
      dsr        <= '0;
      quo        <= '0;
      rem        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      cnt        <= '0;
      out_result <= '0;
    end else if (accept) begin
      op       <= in_op;
      is_w     <= in_is_w;
      mul_op   <= in_op[1:0];
      mul_is_w <= in_is_w;
      mul_a    <= src1;
      mul_b    <= src2;
      dvd      <= a_mag;
      dsr      <= b_mag;
      quo      <= '0;
      rem      <= '0;
      q_neg    <= s1 ^ s2;
      r_neg    <= s1;
      cnt      <= in_is_w ? CW'(31) : CW'(DIV_BITS - 1);
      if (special) out_result <= w_adj(in_is_w, spec_sel);
    end else if (!flush) begin
      if (state == MUL_WAIT && mul_done) out_result <= mul_result;
      if (state == DIV_RUN) begin
        rem      <= ge ? diff[DIV_BITS-1:0] : rem_sh[DIV_BITS-1:0];
        quo[cnt] <= ge;
        cnt      <= cnt - 1'b1;
      end
      if (state == DIV_FIX) out_result <= w_adj(is_w, fix_sel);
    end
  end
endmodule

// File: tb/tb_ysyx_220066_mdu_ctrl.sv
// Directed bench for the MDU sequencer: divide results and latencies,
// multiply handshake, hold behaviour and flush handling.
module tb_ysyx_220066_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_is_w = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        mul_req;
  logic [1:0]  mul_op;
  logic        mul_is_w;
  logic [63:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [63:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;

  int total = 0;
  int bad = 0;

  ysyx_220066_mdu_ctrl #(.DIV_BITS(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_is_w(in_is_w), .src1(src1), .src2(src2), .flush(flush),
    .mul_req(mul_req), .mul_op(mul_op), .mul_is_w(mul_is_w), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_is_w = w; src1 = a; src2 = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    chk({tag, ".busy"}, in_ready, 1'b0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".idle"}, in_ready, 1'b1);
    chk({tag, ".vdrop"}, out_valid, 1'b0);
  endtask

  // Latency is counted in edges from the accept edge to the edge that first samples out_valid.
  task automatic run_div(input string tag, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
    int lat;
    offer(op, w, a, b);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, out_result, exp);
    consume(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.mul_req", mul_req, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_result", out_result, 64'h0);
    chk("rst.mul_a", mul_a, 64'h0);
    chk("rst.mul_op", {62'h0, mul_op}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    run_div("divu",    3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    run_div("remu",    3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    run_div("rem",     3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_div("div",     3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_div("div0",    3'b100, 1'b0, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_div("rem0",    3'b110, 1'b0, 64'd55, 64'd0, 64'd55, 1);
    run_div("divovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
    run_div("removf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
    run_div("divuw",   3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'h0000_0000_0FFF_FFFF, 34);
    run_div("divuwsx", 3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_div("remw",    3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_div("divwovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
    run_div("remuw0",  3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);

    // Multiply handshake with a delayed done and a stalled consumer.
    offer(3'b011, 1'b0, 64'hAAAA, 64'h5555);
    chk("mul.a", mul_a, 64'hAAAA);
    chk("mul.b", mul_b, 64'h5555);
    chk("mul.op", {62'h0, mul_op}, 64'd3);
    chk("mul.is_w", mul_is_w, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mul.req", mul_req, 1'b1);
      chk("mul.novalid", out_valid, 1'b0);
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    mul_done = 1'b1; mul_result = 64'h1234;
    @(posedge clk);
    #1 mul_done = 1'b0; mul_result = 64'hDEAD;
    chk("mul.valid", out_valid, 1'b1);
    chk("mul.reqdrop", mul_req, 1'b0);
    chk("mul.res", out_result, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold.valid", out_valid, 1'b1);
      chk("hold.res", out_result, 64'h1234);
      chk("hold.in_ready", in_ready, 1'b0);
    end
    consume("mul");

    // Flush in the tenth DIV_RUN cycle.
    offer(3'b101, 1'b0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush.in_ready", in_ready, 1'b1);
    chk("flush.out_valid", out_valid, 1'b0);

    // Stale mul_done while idle.
    @(negedge clk);
    mul_done = 1'b1; mul_result = 64'hBEEF;
    @(posedge clk);
    #1 mul_done = 1'b0;
    chk("stale.in_ready", in_ready, 1'b1);
    chk("stale.out_valid", out_valid, 1'b0);
    chk("stale.mul_req", mul_req, 1'b0);
    chk("stale.res", out_result, 64'h1234);

    // mul_done coinciding with flush is discarded.
    offer(3'b000, 1'b1, 64'd5, 64'd6);
    chk("mflush.req", mul_req, 1'b1);
    chk("mflush.is_w", mul_is_w, 1'b1);
    @(negedge clk);
    mul_done = 1'b1; mul_result = 64'h77; flush = 1'b1;
    @(posedge clk);
    #1 mul_done = 1'b0; flush = 1'b0;
    chk("mflush.in_ready", in_ready, 1'b1);
    chk("mflush.out_valid", out_valid, 1'b0);
    chk("mflush.req_drop", mul_req, 1'b0);
    chk("mflush.res", out_result, 64'h1234);

    // Offer during flush is not accepted.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_is_w = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("fsup.in_ready", in_ready, 1'b1);
    chk("fsup.mul_req", mul_req, 1'b0);

    run_div("post", 3'b101, 1'b0, 64'd1000, 64'd33, 64'd30, 66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
